// File: rtl/mips_multicycle_controller_pkg.sv
//==============================================================================
// Module      : mips_multicycle_controller_pkg
// Description : Shared opcodes, R-type func codes, ALU operation codes and the
//               controller state encoding for the multicycle MIPS control path.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mips_multicycle_controller_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_J     = 6'b000010;
    localparam logic [5:0] C_OP_JAL   = 6'b000011;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_BNE   = 6'b000101;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_SLTI  = 6'b001010;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;

    // R-type func codes (IR[5:0])
    localparam logic [5:0] C_FN_JR    = 6'b001000;
    localparam logic [5:0] C_FN_ADD   = 6'b100000;
    localparam logic [5:0] C_FN_SUB   = 6'b100010;
    localparam logic [5:0] C_FN_AND   = 6'b100100;
    localparam logic [5:0] C_FN_OR    = 6'b100101;
    localparam logic [5:0] C_FN_SLT   = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] C_ALU_AND  = 3'b000;
    localparam logic [2:0] C_ALU_OR   = 3'b001;
    localparam logic [2:0] C_ALU_ADD  = 3'b010;
    localparam logic [2:0] C_ALU_SUB  = 3'b110;
    localparam logic [2:0] C_ALU_SLT  = 3'b111;

    // ALU B-operand select
    localparam logic [1:0] C_SRCB_B      = 2'b00;
    localparam logic [1:0] C_SRCB_FOUR   = 2'b01;
    localparam logic [1:0] C_SRCB_SEXT   = 2'b10;
    localparam logic [1:0] C_SRCB_SEXT_SH = 2'b11;

    // PC source select
    localparam logic [1:0] C_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] C_PCSRC_JUMP   = 2'b01;
    localparam logic [1:0] C_PCSRC_REG_A  = 2'b10;
    localparam logic [1:0] C_PCSRC_ALUOUT = 2'b11;

    // Controller states, binary encoded
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_IMM_EXEC  = 4'd9,
        S_IMM_WB    = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_JAL       = 4'd13,
        S_JR        = 4'd14
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mips_multicycle_controller_alu_control.sv
//==============================================================================
// Module      : mips_multicycle_controller_alu_control
// Description : Combinational R-type func to ALU operation decoder. Unknown
//               func codes fall back to ADD.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mips_multicycle_controller_alu_control
    import mips_multicycle_controller_pkg::*;
(
    input  logic [5:0] i_func,
    output logic [2:0] o_alu_op
);

    // Map the func field onto the ALU operation code
    always_comb begin
        o_alu_op = C_ALU_ADD;
        case (i_func)
            C_FN_ADD: o_alu_op = C_ALU_ADD;
            C_FN_SUB: o_alu_op = C_ALU_SUB;
            C_FN_AND: o_alu_op = C_ALU_AND;
            C_FN_OR:  o_alu_op = C_ALU_OR;
            C_FN_SLT: o_alu_op = C_ALU_SLT;
            default:  o_alu_op = C_ALU_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_controller.sv
//==============================================================================
// Module      : mips_multicycle_controller
// Description : Multicycle MIPS control FSM. Sequences fetch, decode, execute,
//               memory and write-back for R-type, lw/sw, addi/slti, beq/bne
//               and j/jal/jr. Outputs are Moore on the state except pc_write
//               in BRANCH, which follows ZERO combinationally.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mips_multicycle_controller
    import mips_multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       ZERO,
    output logic       pc_write,
    output logic       IR_write,
    output logic       reg_dst,
    output logic       jal_reg,
    output logic       pc_to_reg,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_A,
    output logic       I_or_D,
    output logic       mem_write,
    output logic       mem_read,
    output logic [1:0] alu_src_B,
    output logic [1:0] pc_src,
    output logic [2:0] alu_op,
    output logic       instr_done,
    output logic [3:0] state
);

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] w_r_alu_op;
    logic [2:0] w_imm_alu_op;

    mips_multicycle_controller_alu_control u_alu_control (
        .i_func   (func),
        .o_alu_op (w_r_alu_op)
    );

    // slti compares, addi (the only other immediate op reaching here) adds
    assign w_imm_alu_op = (opcode == C_OP_SLTI) ? C_ALU_SLT : C_ALU_ADD;
    assign state        = r_state;

    // State register; a low rst drops any in-flight instruction at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_next_state = r_state;
        pc_write     = 1'b0;
        IR_write     = 1'b0;
        reg_dst      = 1'b0;
        jal_reg      = 1'b0;
        pc_to_reg    = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        alu_src_A    = 1'b0;
        I_or_D       = 1'b0;
        mem_write    = 1'b0;
        mem_read     = 1'b0;
        alu_src_B    = C_SRCB_B;
        pc_src       = C_PCSRC_ALU;
        alu_op       = C_ALU_AND;
        instr_done   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_next_state = S_FETCH;
            end

            S_FETCH: begin
                mem_read     = 1'b1;
                IR_write     = 1'b1;
                alu_src_B    = C_SRCB_FOUR;
                alu_op       = C_ALU_ADD;
                pc_src       = C_PCSRC_ALU;
                pc_write     = 1'b1;
                w_next_state = S_DECODE;
            end

            S_DECODE: begin
                // Branch target precomputed into AluOut for BRANCH
                alu_src_B = C_SRCB_SEXT_SH;
                alu_op    = C_ALU_ADD;
                case (opcode)
                    C_OP_LW, C_OP_SW:   w_next_state = S_MEM_ADDR;
                    C_OP_RTYPE:         w_next_state = (func == C_FN_JR) ? S_JR : S_R_EXEC;
                    C_OP_BEQ, C_OP_BNE: w_next_state = S_BRANCH;
                    C_OP_ADDI, C_OP_SLTI: w_next_state = S_IMM_EXEC;
                    C_OP_J:             w_next_state = S_JUMP;
                    C_OP_JAL:           w_next_state = S_JAL;
                    default: begin
                        // Unsupported opcode retires here with no side effects
                        instr_done   = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end

            S_MEM_ADDR: begin
                alu_src_A    = 1'b1;
                alu_src_B    = C_SRCB_SEXT;
                alu_op       = C_ALU_ADD;
                w_next_state = (opcode == C_OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end

            S_MEM_READ: begin
                alu_src_A    = 1'b1;
                alu_src_B    = C_SRCB_SEXT;
                alu_op       = C_ALU_ADD;
                I_or_D       = 1'b1;
                mem_read     = 1'b1;
                w_next_state = S_MEM_WB;
            end

            S_MEM_WB: begin
                reg_write    = 1'b1;
                mem_to_reg   = 1'b1;
                instr_done   = 1'b1;
                w_next_state = S_FETCH;
            end

            S_MEM_WRITE: begin
                alu_src_A    = 1'b1;
                alu_src_B    = C_SRCB_SEXT;
                alu_op       = C_ALU_ADD;
                I_or_D       = 1'b1;
                mem_write    = 1'b1;
                instr_done   = 1'b1;
                w_next_state = S_FETCH;
            end

            S_R_EXEC: begin
                alu_src_A    = 1'b1;
                alu_src_B    = C_SRCB_B;
                alu_op       = w_r_alu_op;
                w_next_state = S_R_WB;
            end

            S_R_WB: begin
                alu_src_A    = 1'b1;
                alu_src_B    = C_SRCB_B;
                alu_op       = w_r_alu_op;
                reg_dst      = 1'b1;
                reg_write    = 1'b1;
                instr_done   = 1'b1;
                w_next_state = S_FETCH;
            end

            S_IMM_EXEC: begin
                alu_src_A    = 1'b1;
                alu_src_B    = C_SRCB_SEXT;
                alu_op       = w_imm_alu_op;
                w_next_state = S_IMM_WB;
            end

            S_IMM_WB: begin
                alu_src_A    = 1'b1;
                alu_src_B    = C_SRCB_SEXT;
                alu_op       = w_imm_alu_op;
                reg_write    = 1'b1;
                instr_done   = 1'b1;
                w_next_state = S_FETCH;
            end

            S_BRANCH: begin
                alu_src_A    = 1'b1;
                alu_src_B    = C_SRCB_B;
                alu_op       = C_ALU_SUB;
                pc_src       = C_PCSRC_ALUOUT;
                // Mealy: taken decision follows ZERO within this cycle
                pc_write     = (opcode == C_OP_BNE) ? ~ZERO : ZERO;
                instr_done   = 1'b1;
                w_next_state = S_FETCH;
            end

            S_JUMP: begin
                pc_src       = C_PCSRC_JUMP;
                pc_write     = 1'b1;
                instr_done   = 1'b1;
                w_next_state = S_FETCH;
            end

            S_JAL: begin
                // Link register captures PC+4 on the same edge the PC jumps
                pc_src       = C_PCSRC_JUMP;
                pc_write     = 1'b1;
                reg_write    = 1'b1;
                jal_reg      = 1'b1;
                pc_to_reg    = 1'b1;
                instr_done   = 1'b1;
                w_next_state = S_FETCH;
            end

            S_JR: begin
                pc_src       = C_PCSRC_REG_A;
                pc_write     = 1'b1;
                instr_done   = 1'b1;
                w_next_state = S_FETCH;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
